rom_sample_reader: RTL and testbench
====================================

// Module: rom_sample_reader
// PURPOSE
//  Reader/initiator for the synchronous music block ROM: walks ROM addresses, absorbs the ROM's registered read latency,
//  and presents samples as a valid/ready stream to the downstream I2S serializer. Supports one-shot and looped playback,
//  stop mid-stream, and sustains one sample per clk when the consumer is always ready.
// PARAMETERS
//  W          8   sample width in bits; matches ROM row width
//  L          32  ROM length in rows; address width A = $clog2(L)
//  FIFO_DEPTH 4   output buffer entries; >=3 needed for 1 sample/clk throughput
// PORTS
//  clk          in   1  system clock; all state on posedge
//  rst_n        in   1  asynchronous active-low reset
//  start        in   1  pulse: begin playback from address 0 (ignored unless IDLE)
//  stop         in   1  pulse: abort playback, flush buffer
//  loop_en      in   1  1 = wrap to address 0 after last_addr; sampled at each wrap decision
//  last_addr    in   A  final address to play; latched on accepted start; values > L-1 clamp to L-1
//  rom_addr     out  A  registered address to ROM
//  rom_rd_data  in   W  ROM registered read data
//  sample       out  W  head-of-buffer sample
//  sample_valid out  1  sample holds valid data
//  sample_ready in   1  consumer accepts sample when valid&ready at posedge
//  busy         out  1  high in RUN or DRAIN
//  done         out  1  one-clk pulse on natural end of one-shot playback
// BEHAVIOUR
//  Reset: state=IDLE, rom_addr=0, sample=0, sample_valid=0, busy=0, done=0, buffer empty, inflight=0.
//  Read timing: issue = rom_addr registered at edge E; ROM registers data at E+1; reader writes rom_rd_data into
//   buffer at edge E+2. Fixed read latency 2 edges. inflight = issued reads not yet written (0..2).
//  Issue rule (RUN only): issue at an edge iff count + inflight < FIFO_DEPTH, counting any pop at that edge.
//   Address sequence 0,1,...,last_addr_q; after last_addr_q: loop_en=1 -> next issue is 0; loop_en=0 -> DRAIN.
//  Buffer: FIFO, sample/sample_valid reflect head; pop on valid&ready; simultaneous push+pop keeps count. Never
//   overflows (credit rule guarantees space); sample stable while valid&!ready.
//  FSM:
//   IDLE : start&!stop -> RUN, latch last_addr_q, first issue (rom_addr=0) at the same edge.
//   RUN  : stop -> IDLE; last address issued with loop_en=0 -> DRAIN.
//   DRAIN: no issues; stop -> IDLE; buffer empty & inflight=0 -> IDLE with done=1 for exactly one clk.
//  Stop (RUN or DRAIN): at that edge buffer flushed, sample_valid=0 next cycle, inflight returns discarded,
//   rom_addr returns to 0, no done pulse. start and stop same cycle: stop wins; start in RUN/DRAIN ignored.
//  last_addr=0: one-shot plays exactly one sample; looped replays address 0 continuously.
//  busy is registered: 1 in cycle after accepted start, 0 in cycle after return to IDLE.
//  Reset asserted mid-operation: immediate return to reset values regardless of state.
//  Latency: start edge -> sample_valid=1 after 3rd edge (start edge + 2). Always-ready consumer: 1 sample/clk.
// TESTING
//  1 ROM=0x10+i, last_addr=3, loop_en=0, ready=1: start -> samples 10,11,12,13 back-to-back, first valid
//    3rd edge after start, done one pulse after 13 accepted, busy drops next cycle.
//  2 Backpressure: same setup, ready toggles 1,0,0,1,...: no sample lost/duplicated, order 10..13, rom_addr never
//    runs >FIFO_DEPTH ahead, sample held stable while ready=0.
//  3 Loop: last_addr=2, loop_en=1, ready=1 for 10 samples -> 10,11,12,10,11,12,10,11,12,10; clear loop_en ->
//    finishes current pass to 12, then done.
//  4 Stop mid-run: after 2 samples pulse stop with 2 reads inflight -> sample_valid=0 next cycle, no done, no stale
//    data after new start (restarts at 10).
//  5 Edges: last_addr=0 one-shot -> single sample 10 then done; last_addr=40 (L=32) -> clamps, 32 samples;
//    start+stop same cycle -> stays IDLE.
//  6 Async reset asserted in RUN with full buffer -> all outputs at reset values without clk edge.

Source files
------------

// File: rtl/rom_sample_reader.sv
// -----------------------------------------------------------------------------
// rom_sample_reader
//
// Reads samples out of a synchronous block ROM and hands them to the I2S
// serializer as a valid/ready stream. Addresses run 0..last_addr, either once
// (one-shot) or repeatedly (loop_en). The ROM's two-edge read latency is hidden
// behind a small output FIFO and a credit check, so a consumer that is always
// ready receives one sample per clk.
//
// Read pipeline, for an address issued at edge E:
//   E   : rom_addr registered,          rd_v1_reg set
//   E+1 : ROM registers its read data,  rd_v2_reg set
//   E+2 : rom_rd_data written into the FIFO
//
// Ports
//   clk          in   1  system clock, all state on posedge
//   rst_n        in   1  asynchronous active-low reset
//   start        in   1  pulse, begin playback at address 0 (honoured only in IDLE)
//   stop         in   1  pulse, abort playback and flush the buffer
//   loop_en      in   1  wrap to address 0 after last_addr (checked at each wrap)
//   last_addr    in   A  final address to play, latched on start, clamped to L-1
//   rom_addr     out  A  registered ROM address
//   rom_rd_data  in   W  registered ROM read data
//   sample       out  W  head-of-buffer sample
//   sample_valid out  1  sample holds valid data
//   sample_ready in   1  consumer takes sample when valid & ready at posedge
//   busy         out  1  high while playing or draining
//   done         out  1  one-clk pulse at natural end of one-shot playback
// -----------------------------------------------------------------------------
module rom_sample_reader #(
    parameter int W          = 8,
    parameter int L          = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int A         = (L > 1) ? $clog2(L) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic         loop_en,
    input  logic [A-1:0] last_addr,
    output logic [A-1:0] rom_addr,
    input  logic [W-1:0] rom_rd_data,
    output logic [W-1:0] sample,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic         busy,
    output logic         done
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);
    localparam logic [CW+1:0] CREDITS = (CW + 2)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_reg, state_next;

    logic [A-1:0]   rom_addr_reg, rom_addr_next;
    logic [A-1:0]   last_addr_q_reg, last_addr_q_next;
    logic [A-1:0]   last_clamped;
    logic [A-1:0]   issue_addr;
    logic           busy_reg;
    logic           done_reg, done_next;

    // One bit per read-pipeline stage; together they form the inflight count.
    logic           rd_v1_reg;
    logic           rd_v2_reg;

    logic           issue;
    logic           flush;
    logic           has_credit;
    logic [CW+1:0]  credit_used;

    logic [W-1:0]          mem_reg [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_reg;
    logic [PW-1:0]         wr_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  push;
    logic                  pop;
    logic [FIFO_DEPTH-1:0] wr_en;

    // -------------------------------------------------------------------------
    // last_addr clamp; only needed when L does not fill the address space
    // -------------------------------------------------------------------------
    generate
        if (L < (1 << A)) begin : g_clamp
            localparam logic [A-1:0] LAST_MAX = A'(L - 1);
            assign last_clamped = (last_addr > LAST_MAX) ? LAST_MAX : last_addr;
        end else begin : g_no_clamp
            assign last_clamped = last_addr;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Stream handshake and credit accounting
    // -------------------------------------------------------------------------
    assign sample_valid = (count_reg != '0);
    assign pop          = sample_valid & sample_ready;
    assign push         = rd_v2_reg & ~flush;

    // Entries already owned (buffered + in the ROM pipeline), less the one
    // leaving at this edge. A data beat moving from the pipeline into the
    // buffer does not change the total, so push is not counted separately.
    assign credit_used = {2'b00, count_reg}
                       + (CW + 2)'(rd_v1_reg)
                       + (CW + 2)'(rd_v2_reg)
                       - (CW + 2)'(pop);
    assign has_credit  = (credit_used < CREDITS);

    // Address following the one currently on rom_addr.
    assign issue_addr = (rom_addr_reg == last_addr_q_reg) ? '0 : rom_addr_reg + 1'b1;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state, issue control, address generation
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        rom_addr_next    = rom_addr_reg;
        last_addr_q_next = last_addr_q_reg;
        issue            = 1'b0;
        flush            = 1'b0;
        done_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                // Buffer and pipeline are always empty here, so the first
                // read can go out on the start edge itself.
                if (start && !stop) begin
                    last_addr_q_next = last_clamped;
                    rom_addr_next    = '0;
                    issue            = 1'b1;
                    // A one-shot of a single row has already issued its last read.
                    if ((last_clamped == '0) && !loop_en) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = RUN;
                    end
                end
            end

            RUN: begin
                if (stop) begin
                    flush         = 1'b1;
                    rom_addr_next = '0;
                    state_next    = IDLE;
                end else if (has_credit) begin
                    issue         = 1'b1;
                    rom_addr_next = issue_addr;
                    // loop_en is consulted only when the final row goes out.
                    if ((issue_addr == last_addr_q_reg) && !loop_en) begin
                        state_next = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (stop) begin
                    flush         = 1'b1;
                    rom_addr_next = '0;
                    state_next    = IDLE;
                end else if ((count_reg == '0) && !rd_v1_reg && !rd_v2_reg) begin
                    rom_addr_next = '0;
                    done_next     = 1'b1;
                    state_next    = IDLE;
                end
            end

            default: begin
                flush         = 1'b1;
                rom_addr_next = '0;
                state_next    = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers and read pipeline
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_reg    <= '0;
            last_addr_q_reg <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            rd_v1_reg       <= 1'b0;
            rd_v2_reg       <= 1'b0;
        end else begin
            rom_addr_reg    <= rom_addr_next;
            last_addr_q_reg <= last_addr_q_next;
            busy_reg        <= (state_next != IDLE);
            done_reg        <= done_next;
            rd_v1_reg       <= issue;
            // Reads still in the ROM when stop hits are simply forgotten.
            rd_v2_reg       <= rd_v1_reg & ~flush;
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Entries are reset so that sample reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= rom_rd_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_MAX) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_MAX) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rom_addr = rom_addr_reg;
    assign sample   = mem_reg[rd_ptr_reg];
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_rom_sample_reader.sv
// -----------------------------------------------------------------------------
// tb_rom_sample_reader
//
// Directed bench for rom_sample_reader. The ROM model returns 0x10 + address
// one edge after the address is presented. A second reader built with L=20
// shares all inputs and is used to observe last_addr clamping.
// -----------------------------------------------------------------------------
module tb_rom_sample_reader;

    localparam int W  = 8;
    localparam int L  = 32;
    localparam int L2 = 20;
    localparam int FD = 4;
    localparam int A  = 5;

    logic         clk          = 1'b0;
    logic         rst_n        = 1'b1;
    logic         start        = 1'b0;
    logic         stop         = 1'b0;
    logic         loop_en      = 1'b0;
    logic         sample_ready = 1'b0;
    logic [A-1:0] last_addr    = '0;

    logic [A-1:0] rom_addr, rom_addr2;
    logic [W-1:0] rom_rd_data, rom_rd_data2;
    logic [W-1:0] sample, sample2;
    logic         sample_valid, sample_valid2;
    logic         busy, busy2, done, done2;

    int           vec_cnt   = 0;
    int           err_cnt   = 0;
    int           acc2      = 0;
    int           done2_cnt = 0;
    logic [W-1:0] last2     = '0;
    logic         acc2_clr  = 1'b0;

    always #5 clk = ~clk;

    // Synchronous ROM models: data registered one edge after the address.
    always @(posedge clk) begin
        rom_rd_data  <= 8'h10 + 8'(rom_addr);
        rom_rd_data2 <= 8'h10 + 8'(rom_addr2);
    end

    // Tally of what the L=20 reader delivers.
    always @(posedge clk) begin
        if (acc2_clr) begin
            acc2      <= 0;
            done2_cnt <= 0;
        end else begin
            if (sample_valid2 && sample_ready) begin
                acc2  <= acc2 + 1;
                last2 <= sample2;
            end
            if (done2) begin
                done2_cnt <= done2_cnt + 1;
            end
        end
    end

    rom_sample_reader #(.W(W), .L(L), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .last_addr    (last_addr),
        .rom_addr     (rom_addr),
        .rom_rd_data  (rom_rd_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done)
    );

    rom_sample_reader #(.W(W), .L(L2), .FIFO_DEPTH(FD)) dut_clamp (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .last_addr    (last_addr),
        .rom_addr     (rom_addr2),
        .rom_rd_data  (rom_rd_data2),
        .sample       (sample2),
        .sample_valid (sample_valid2),
        .sample_ready (sample_ready),
        .busy         (busy2),
        .done         (done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then confirm busy, first address and the 3-edge latency.
    task automatic do_start(input string tag, input int last, input logic lp);
        int e;
        last_addr = A'(last);
        loop_en   = lp;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy"}, busy, 1);
        check({tag, " addr0"}, rom_addr, 0);
        e = 1;
        while (!sample_valid && e < 10) begin
            tick();
            e++;
        end
        check({tag, " latency"}, e, 3);
    endtask

    // Accept n samples; sample index k should carry 0x10 + (k mod (last+1)).
    // bp: ready pattern 1,0,0 repeating; otherwise a new sample every cycle.
    task automatic collect(input string tag, input int k0, input int n, input int last,
                           input bit bp, input bit lead);
        int           got     = 0;
        int           cyc     = 0;
        bit           stalled = 1'b0;
        logic [W-1:0] held    = '0;
        while (got < n && cyc < 8 * n + 20) begin
            sample_ready = bp ? (cyc % 3 == 0) : 1'b1;
            if (stalled) begin
                check({tag, " hold valid"}, sample_valid, 1);
                check({tag, " hold data"}, sample, held);
            end
            if (!bp) begin
                check({tag, " b2b"}, sample_valid, 1);
            end
            if (lead && busy) begin
                check({tag, " lead"}, (int'(rom_addr) + 1 - (k0 + got)) <= FD, 1);
            end
            if (sample_valid && sample_ready) begin
                check({tag, " data"}, sample, 8'h10 + 8'((k0 + got) % (last + 1)));
                got++;
                stalled = 1'b0;
            end else begin
                stalled = sample_valid;
                held    = sample;
            end
            tick();
            cyc++;
        end
        sample_ready = 1'b1;
        check({tag, " count"}, got, n);
    endtask

    // Called right after the final acceptance: done must rise on the next edge.
    task automatic wait_done(input string tag);
        int e = 0;
        while (!done && e < 20) begin
            tick();
            e++;
        end
        check({tag, " done edge"}, e, 1);
        check({tag, " busy low"}, busy, 0);
        check({tag, " valid low"}, sample_valid, 0);
        tick();
        check({tag, " done pulse"}, done, 0);
    endtask

    initial begin
        // ---------------- reset ----------------
        sample_ready = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst rom_addr", rom_addr, 0);
        check("rst sample", sample, 0);
        check("rst valid", sample_valid, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- 1: one-shot, always ready ----------------
        do_start("t1", 3, 1'b0);
        collect("t1", 0, 4, 3, 1'b0, 1'b0);
        check("t1 no early done", done, 0);
        check("t1 busy in drain", busy, 1);
        wait_done("t1");

        // ---------------- 2: backpressure ----------------
        do_start("t2", 3, 1'b0);
        collect("t2", 0, 4, 3, 1'b1, 1'b1);
        wait_done("t2");

        // ---------------- 3: looped, then loop_en cleared ----------------
        // Three reads are ahead of the consumer, so after the 10th sample the
        // addresses 0 is already issued; the wrap decision at the next
        // address 2 sees loop_en=0, leaving 1,2,0,1,2 still to come.
        do_start("t3", 2, 1'b1);
        collect("t3", 0, 10, 2, 1'b0, 1'b0);
        loop_en = 1'b0;
        collect("t3 tail", 10, 5, 2, 1'b0, 1'b0);
        wait_done("t3");

        // ---------------- 4: stop with two reads in flight ----------------
        do_start("t4", 7, 1'b0);
        collect("t4", 0, 2, 7, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t4 valid after stop", sample_valid, 0);
        check("t4 busy after stop", busy, 0);
        check("t4 addr after stop", rom_addr, 0);
        check("t4 done after stop", done, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4 no stale valid", sample_valid, 0);
            check("t4 no done", done, 0);
        end
        do_start("t4r", 3, 1'b0);
        collect("t4r", 0, 4, 3, 1'b0, 1'b0);
        wait_done("t4r");

        // ---------------- 5a: last_addr=0 one-shot ----------------
        do_start("t5a", 0, 1'b0);
        collect("t5a", 0, 1, 0, 1'b0, 1'b0);
        wait_done("t5a");

        // ---------------- 5b: last_addr=0 looped, then stop ----------------
        do_start("t5b", 0, 1'b1);
        collect("t5b", 0, 6, 0, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop    = 1'b0;
        loop_en = 1'b0;
        check("t5b valid after stop", sample_valid, 0);
        check("t5b busy after stop", busy, 0);

        // ---------------- 5c: clamp (L=20 reader clamps 25 to 19) ----------------
        acc2_clr = 1'b1;
        tick();
        acc2_clr = 1'b0;
        do_start("t5c", 25, 1'b0);
        collect("t5c", 0, 26, 25, 1'b0, 1'b0);
        wait_done("t5c");
        check("t5c clamp count", acc2, 20);
        check("t5c clamp last", last2, 8'h23);
        check("t5c clamp done", done2_cnt, 1);
        check("t5c clamp busy", busy2, 0);

        // ---------------- 5d: start and stop together ----------------
        last_addr = 5'd3;
        start     = 1'b1;
        stop      = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("t5d busy", busy, 0);
        check("t5d addr", rom_addr, 0);
        tick();
        tick();
        check("t5d valid", sample_valid, 0);
        check("t5d busy later", busy, 0);

        // ---------------- 6: async reset with a full buffer ----------------
        sample_ready = 1'b0;
        do_start("t6", 7, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("t6 full valid", sample_valid, 1);
        check("t6 full head", sample, 8'h10);
        check("t6 full addr", rom_addr, 3);
        check("t6 full busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async addr", rom_addr, 0);
        check("t6 async sample", sample, 0);
        check("t6 async valid", sample_valid, 0);
        check("t6 async busy", busy, 0);
        check("t6 async done", done, 0);
        tick();
        rst_n        = 1'b1;
        sample_ready = 1'b1;
        tick();
        check("t6 post valid", sample_valid, 0);
        check("t6 post busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
